// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read path (AR + R) between NUM_MASTERS requesters, one burst at a time.
// Optional macro AXI4_RD_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module axi4_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_MASTERS-1:0]        s_arvalid,
  output logic [NUM_MASTERS-1:0]        s_arready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_arid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MASTERS*8-1:0]      s_arlen,
  input  logic [NUM_MASTERS*3-1:0]      s_arsize,
  input  logic [NUM_MASTERS*2-1:0]      s_arburst,
  output logic [NUM_MASTERS-1:0]        s_rvalid,
  input  logic [NUM_MASTERS-1:0]        s_rready,
  output logic [ID_WIDTH-1:0]           s_rid,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ID_WIDTH-1:0]           m_arid,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [ID_WIDTH-1:0]           m_rid,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  output logic [GW-1:0]                 grant
);

  // state | meaning
  // IDLE  | no owner; arbitrate among s_arvalid
  // ADDR  | granted master's AR passed downstream until handshake
  // DATA  | R beats routed to granted master until RLAST handshake
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   winner;
  logic            found;
  logic            burst_done;

  assign s_rid   = m_rid;
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;
  assign grant   = grant_q;

`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && s_arvalid[i]) begin
        winner = GW'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [GW-1:0] last_q;

  // Two passes: first above the last owner, then wrap to the lowest requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && s_arvalid[i] && (GW'(i) > last_q)) begin
        winner = GW'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && s_arvalid[i]) begin
        winner = GW'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      last_q <= GW'(NUM_MASTERS - 1);
    end else if (burst_done) begin
      last_q <= grant_q;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    burst_done = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s_arready  = '0;
    s_rvalid   = '0;
    m_arid     = '0;
    m_araddr   = '0;
    m_arlen    = '0;
    m_arsize   = '0;
    m_arburst  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GW'(i)) begin
        m_arid    = s_arid[i*ID_WIDTH +: ID_WIDTH];
        m_araddr  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen   = s_arlen[i*8 +: 8];
        m_arsize  = s_arsize[i*3 +: 3];
        m_arburst = s_arburst[i*2 +: 2];
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_q == GW'(i)) begin
            m_arvalid    = s_arvalid[i];
            s_arready[i] = m_arready;
          end
        end
        if (m_arvalid && m_arready) state_d = DATA;
      end
      DATA: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (grant_q == GW'(i)) begin
            s_rvalid[i] = m_rvalid;
            m_rready    = s_rready[i];
          end
        end
        if (m_rvalid && m_rready && m_rlast) begin
          burst_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Scoreboard bench for axi4_rd_arbiter: expected grants and R data are queued when driven, popped when seen.
module tb_axi4_rd_arbiter;
  localparam int N  = 2;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 1;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*IW-1:0] s_arid;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [IW-1:0]   s_rid;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            m_arvalid, m_arready;
  logic [IW-1:0]   m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_rvalid, m_rready;
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic [GW-1:0]   grant;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_grant_q[$];
  logic [DW-1:0] exp_data_q[$];

  axi4_rd_arbiter #(.NUM_MASTERS(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .grant(grant)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Serves one burst from the current IDLE/ADDR point: AR handshake, then len+1 R beats.
  task automatic serve_burst(input int len, input logic [DW-1:0] base, input bit drop_valid);
    int eg;
    int waited;
    logic [DW-1:0] ed;
    logic [N-1:0] onehot;
    eg = exp_grant_q.pop_front();
    onehot = '0;
    onehot[eg] = 1'b1;
    waited = 0;
    #1;
    while (m_arvalid !== 1'b1 && waited < 10) begin
      step();
      #1;
      waited++;
    end
    chk_cnt++;
    if (m_arvalid !== 1'b1) $display("FAIL ar_wait: m_arvalid=%b required 1", m_arvalid);
    else pass_cnt++;
    chk_cnt++;
    if (grant !== eg[GW-1:0]) $display("FAIL grant_order: grant=%0d required %0d", grant, eg);
    else pass_cnt++;
    chk_cnt++;
    if (s_arready !== onehot) $display("FAIL s_arready_route: s_arready=%b required %b", s_arready, onehot);
    else pass_cnt++;
    step();
    if (drop_valid) s_arvalid[eg] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + DW'(b);
      m_rlast  = (b == len);
      exp_data_q.push_back(base + DW'(b));
      #1;
      chk_cnt++;
      if (s_rvalid !== onehot) $display("FAIL rvalid_route: s_rvalid=%b required %b", s_rvalid, onehot);
      else pass_cnt++;
      if (s_rvalid[eg] && s_rready[eg] && exp_data_q.size() > 0) begin
        ed = exp_data_q.pop_front();
        chk_cnt++;
        if (s_rdata !== ed) $display("FAIL rdata: s_rdata=%h required %h", s_rdata, ed);
        else pass_cnt++;
      end
      step();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    s_arvalid = '1; s_rready = '1; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; m_arready = 1'b1; m_rvalid = 1'b1; m_rid = '0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b1;
    ARESETn = 1'b0;
    step(); step();
    chk_cnt++;
    if ({m_arvalid, m_rready, s_arready, s_rvalid} !== '0)
      $display("FAIL reset_outputs: arv=%b rr=%b sar=%b srv=%b required all 0", m_arvalid, m_rready, s_arready, s_rvalid);
    else pass_cnt++;
    chk_cnt++;
    if (grant !== '0) $display("FAIL reset_grant: grant=%0d required 0", grant);
    else pass_cnt++;
    s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    step();
  endtask

  task automatic test_contention();
    s_araddr = {32'h0000_B000, 32'h0000_A000};
    s_arlen  = {8'd1, 8'd1};
`ifdef AXI4_RD_ARB_FIXED_PRIO_EN
    exp_grant_q = '{0, 0, 0, 0};
`else
    exp_grant_q = '{0, 1, 0, 1};
`endif
    s_arvalid = '1;
    for (int k = 0; k < 4; k++) serve_burst(1, DW'(32'h10 * (k + 1)), 1'b0);
    s_arvalid = '0;
    step();
  endtask

  task automatic test_single();
    s_araddr[AW +: AW] = 32'h0000_1000;
    s_arlen[8 +: 8]    = 8'd3;
    s_arvalid[1] = 1'b1;
    #1;
    chk_cnt++;
    if (m_arvalid !== 1'b0) $display("FAIL arb_latency_idle: m_arvalid=%b required 0", m_arvalid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_1000 || m_arlen !== 8'd3)
      $display("FAIL ar_mux: arvalid=%b araddr=%h arlen=%0d required 1 00001000 3", m_arvalid, m_araddr, m_arlen);
    else pass_cnt++;
    exp_grant_q.push_back(1);
    serve_burst(3, 32'hA0, 1'b1);
    #1;
    chk_cnt++;
    if (grant !== 1'b1 || m_arvalid !== 1'b0 || s_rvalid !== '0)
      $display("FAIL single_idle: grant=%0d arvalid=%b rvalid=%b required 1 0 00", grant, m_arvalid, s_rvalid);
    else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    int b;
    int cyc;
    int delivered;
    bit pushed;
    logic [DW-1:0] ed;
    s_araddr[0 +: AW] = 32'h0000_2000;
    s_arlen[0 +: 8]   = 8'd3;
    m_arready = 1'b0;
    s_arvalid[0] = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++;
      if (m_arvalid !== 1'b1 || s_arready !== 2'b00)
        $display("FAIL arready_stall: arvalid=%b s_arready=%b required 1 00", m_arvalid, s_arready);
      else pass_cnt++;
      step();
    end
    m_arready = 1'b1;
    #1;
    chk_cnt++;
    if (s_arready !== 2'b01) $display("FAIL arready_mirror: s_arready=%b required 01", s_arready);
    else pass_cnt++;
    step();
    s_arvalid[0] = 1'b0;
    #1;
    chk_cnt++;
    if (m_arvalid !== 1'b0) $display("FAIL single_handshake: m_arvalid=%b required 0", m_arvalid);
    else pass_cnt++;
    b = 0; cyc = 0; delivered = 0; pushed = 1'b0;
    while (b <= 3 && cyc < 30) begin
      m_rvalid    = 1'b1;
      m_rdata     = 32'hA0 + DW'(b);
      m_rlast     = (b == 3);
      s_rready[0] = (cyc % 2 == 0);
      if (!pushed) begin
        exp_data_q.push_back(32'hA0 + DW'(b));
        pushed = 1'b1;
      end
      #1;
      chk_cnt++;
      if (m_rready !== s_rready[0]) $display("FAIL rready_mirror: m_rready=%b required %b", m_rready, s_rready[0]);
      else pass_cnt++;
      if (s_rvalid[0] && s_rready[0] && exp_data_q.size() > 0) begin
        ed = exp_data_q.pop_front();
        delivered++;
        chk_cnt++;
        if (s_rdata !== ed) $display("FAIL bp_rdata: s_rdata=%h required %h", s_rdata, ed);
        else pass_cnt++;
      end
      if (s_rready[0]) begin
        b++;
        pushed = 1'b0;
      end
      step();
      cyc++;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '1;
    chk_cnt++;
    if (delivered !== 4) $display("FAIL bp_beat_count: delivered=%0d required 4", delivered);
    else pass_cnt++;
    step();
  endtask

  task automatic test_single_beat();
    s_arlen = '0;
    s_arvalid[1] = 1'b1;
    exp_grant_q.push_back(1);
    serve_burst(0, 32'hB0, 1'b1);
    s_arvalid[0] = 1'b1;
    #1;
    chk_cnt++;
    if (m_arvalid !== 1'b0) $display("FAIL dead_cycle: m_arvalid=%b required 0", m_arvalid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (m_arvalid !== 1'b1 || grant !== 1'b0)
      $display("FAIL next_grant: arvalid=%b grant=%0d required 1 0", m_arvalid, grant);
    else pass_cnt++;
    exp_grant_q.push_back(0);
    serve_burst(0, 32'hC0, 1'b1);
    step();
  endtask

  task automatic test_spurious();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_cnt++;
      if (m_rready !== 1'b0 || s_rvalid !== '0)
        $display("FAIL spurious_r: m_rready=%b s_rvalid=%b required 0 00", m_rready, s_rvalid);
      else pass_cnt++;
      step();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] ed;
    s_arlen[8 +: 8] = 8'd7;
    m_arready = 1'b1;
    s_arvalid[1] = 1'b1;
    step();
    chk_cnt++;
    if (grant !== 1'b1) $display("FAIL mid_grant: grant=%0d required 1", grant);
    else pass_cnt++;
    step();
    s_arvalid[1] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hD0 + DW'(b);
      m_rlast  = 1'b0;
      exp_data_q.push_back(32'hD0 + DW'(b));
      #1;
      if (s_rvalid[1] && s_rready[1] && exp_data_q.size() > 0) begin
        ed = exp_data_q.pop_front();
        chk_cnt++;
        if (s_rdata !== ed) $display("FAIL mid_rdata: s_rdata=%h required %h", s_rdata, ed);
        else pass_cnt++;
      end
      step();
    end
    m_rvalid  = 1'b1;
    m_rdata   = 32'hD2;
    s_arvalid = '1;
    #1;
    ARESETn = 1'b0;
    #1;
    chk_cnt++;
    if ({m_arvalid, m_rready, s_arready, s_rvalid} !== '0 || grant !== '0)
      $display("FAIL async_reset: arv=%b rr=%b sar=%b srv=%b grant=%0d required all 0",
               m_arvalid, m_rready, s_arready, s_rvalid, grant);
    else pass_cnt++;
    m_rvalid = 1'b0;
    step();
    @(negedge ACLK);
    ARESETn = 1'b1;
    step();
    chk_cnt++;
    if (grant !== 1'b0 || m_arvalid !== 1'b1)
      $display("FAIL post_reset_grant: grant=%0d arvalid=%b required 0 1", grant, m_arvalid);
    else pass_cnt++;
    s_arvalid = '0;
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_single_beat();
    test_spurious();
    test_reset_mid_burst();
    chk_cnt++;
    if (exp_data_q.size() != 0) $display("FAIL scoreboard_empty: %0d beats left required 0", exp_data_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
